// File: rtl/daq_tx_arbiter_if.sv
// Bundle of the source-side and link-side signals around the tx arbiter.
// master = the arbiter itself, slave = packetisers plus link serialiser.
`timescale 1ns/1ps
interface daq_tx_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_SRC-1:0]        src_en;
  logic [NUM_SRC*DATA_W-1:0] s_data;
  logic [NUM_SRC-1:0]        s_valid;
  logic [NUM_SRC-1:0]        s_last;
  logic [NUM_SRC-1:0]        s_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      tx_last;
  logic [NUM_SRC-1:0]        grant;
  logic                      busy;
  logic [NUM_SRC*16-1:0]     pkt_cnt;
  logic                      stall_err;
  logic                      dbg_state;

  modport master (
    input  src_en, s_data, s_valid, s_last, tx_ready,
    output s_ready, tx_data, tx_valid, tx_last, grant, busy, pkt_cnt, stall_err, dbg_state
  );

  modport slave (
    output src_en, s_data, s_valid, s_last, tx_ready,
    input  s_ready, tx_data, tx_valid, tx_last, grant, busy, pkt_cnt, stall_err, dbg_state
  );
endinterface

// File: rtl/daq_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one tx link between NUM_SRC packet sources,
// with per-source packet counters and a sticky mid-packet stall watchdog.
`timescale 1ns/1ps
module daq_tx_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int DATA_W      = 8,
  parameter int STALL_LIMIT = 16
) (
  input logic              clk,
  input logic              rst,
  daq_tx_arbiter_if.master bus
);
  // Handshake: a beat moves on any cycle where valid && ready; a valid beat is held
  // stable with its data/last until accepted. The link side is a straight
  // pass-through of the granted source, so this holds whenever the sources obey it.

  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_gnt;
  logic [GW-1:0]       r_rr_ptr;
  logic [GW-1:0]       w_pick;
  logic [GW-1:0]       w_rr_nxt;
  logic                w_pick_vld;
  logic [NUM_SRC-1:0]  w_req;
  logic [15:0]         r_pkt_cnt [NUM_SRC];
  logic [SW-1:0]       r_stall_cnt;
  logic                r_stall_err;
  logic                w_lock;
  logic                w_g_valid;
  logic                w_g_last;
  logic [DATA_W-1:0]   w_g_data;
  logic                w_xfer;
  logic                w_end;

  // Round-robin pick: scan descending offsets so the smallest offset from rr_ptr wins.
  always_comb begin
    logic [GW:0] w_sum;
    w_req      = bus.s_valid & bus.src_en;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_sum      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(NUM_SRC)) w_sum = w_sum - (GW+1)'(NUM_SRC);
      if (w_req[w_sum[GW-1:0]]) begin
        w_pick     = w_sum[GW-1:0];
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    logic [GW:0] w_inc;
    w_inc = {1'b0, r_gnt} + (GW+1)'(1);
    if (w_inc >= (GW+1)'(NUM_SRC)) w_inc = '0;
    w_rr_nxt = w_inc[GW-1:0];
  end

  // Mux the granted source; outputs are forced quiet while rst is high.
  assign w_lock = (r_state == ST_LOCK) && !rst;

  always_comb begin
    w_g_valid    = 1'b0;
    w_g_last     = 1'b0;
    w_g_data     = '0;
    bus.s_ready  = '0;
    bus.grant    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_gnt == GW'(i)) begin
        w_g_valid = bus.s_valid[i];
        w_g_last  = bus.s_last[i];
        w_g_data  = bus.s_data[i*DATA_W +: DATA_W];
        if (w_lock) begin
          bus.s_ready[i] = bus.tx_ready;
          bus.grant[i]   = 1'b1;
        end
      end
    end
    bus.tx_data  = w_lock ? w_g_data : '0;
    bus.tx_valid = w_lock && w_g_valid;
    bus.tx_last  = w_lock && w_g_last;
  end

  assign w_xfer = (r_state == ST_LOCK) && w_g_valid && bus.tx_ready;
  assign w_end  = w_xfer && w_g_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_vld) w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_end)      w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) r_pkt_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_pick_vld) r_gnt <= w_pick;
      if (w_end) r_rr_ptr <= w_rr_nxt;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_end && r_gnt == GW'(i)) r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
      end
      // Watchdog counts only source-side starvation; link backpressure has valid=1.
      if (r_state != ST_LOCK || w_g_valid) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != SW'(STALL_LIMIT)) begin
        r_stall_cnt <= r_stall_cnt + SW'(1);
        if (r_stall_cnt == SW'(STALL_LIMIT - 1)) r_stall_err <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.pkt_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) bus.pkt_cnt[i*16 +: 16] = r_pkt_cnt[i];
  end

  assign bus.busy      = (r_state == ST_LOCK);
  assign bus.stall_err = r_stall_err;
  assign bus.dbg_state = r_state;
endmodule
